// File: rtl/sim_mem_lsu_if.sv
// Bundle between the core memory stage, the LSU and the simulation memory data port.
// The LSU takes the slave side; the core plus memory model take the master side.
interface sim_mem_lsu_if #(
    parameter int XLEN = 64
);
    // Handshakes: a transfer happens on a posedge where valid and ready are both
    // high; the sender holds valid and its payload stable until that edge, and
    // the receiver may raise or drop ready freely.
    logic            req_valid;
    logic            req_ready;
    logic [XLEN-1:0] req_addr;
    logic            req_wen;
    logic [1:0]      req_size;
    logic            req_signed;
    logic [XLEN-1:0] req_wdata;

    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] resp_data;
    logic            resp_err;

    logic [XLEN-1:0] daddr;
    logic [XLEN-1:0] dmask;
    logic [XLEN-1:0] dwdata;
    logic            dwen;
    logic [XLEN-1:0] drdata;

    modport master (
        output req_valid, req_addr, req_wen, req_size, req_signed, req_wdata,
        output resp_ready, drdata,
        input  req_ready, resp_valid, resp_data, resp_err,
        input  daddr, dmask, dwdata, dwen
    );

    modport slave (
        input  req_valid, req_addr, req_wen, req_size, req_signed, req_wdata,
        input  resp_ready, drdata,
        output req_ready, resp_valid, resp_data, resp_err,
        output daddr, dmask, dwdata, dwen
    );
endinterface

// File: rtl/sim_mem_lsu.sv
// Load/store unit driving the simulation memory data port: one request at a time,
// byte-lane alignment of store data and extraction/extension of load data.
module sim_mem_lsu #(
    parameter int XLEN = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    sim_mem_lsu_if.slave bus,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t     state;
    logic [2:0] off_q;
    logic [1:0] size_q;
    logic       signed_q;
    logic       wen_q;

    logic [2:0]      req_off;
    logic [7:0]      lanes;
    logic [7:0]      lane_bits;
    logic            misaligned;
    logic [XLEN-1:0] req_mask;
    logic [XLEN-1:0] rd_shift;
    logic [XLEN-1:0] load_data;

    assign bus.req_ready = (state == IDLE);
    assign dbg_state     = state;

    // Request decode: byte lanes touched and alignment check.
    always_comb begin
        req_off    = bus.req_addr[2:0];
        lanes      = 8'hFF;
        misaligned = 1'b0;
        unique case (bus.req_size)
            2'd0: begin lanes = 8'h01; misaligned = 1'b0;             end
            2'd1: begin lanes = 8'h03; misaligned = req_off[0];       end
            2'd2: begin lanes = 8'h0F; misaligned = |req_off[1:0];    end
            default: begin lanes = 8'hFF; misaligned = |req_off;      end
        endcase
        lane_bits = lanes << req_off;
        for (int i = 0; i < 8; i++) begin
            req_mask[8*i +: 8] = {8{lane_bits[i]}};
        end
    end

    // Load result: shift the addressed lanes down, then truncate and extend.
    always_comb begin
        rd_shift = bus.drdata >> {off_q, 3'b000};
        unique case (size_q)
            2'd0:    load_data = {{56{signed_q & rd_shift[7]}},  rd_shift[7:0]};
            2'd1:    load_data = {{48{signed_q & rd_shift[15]}}, rd_shift[15:0]};
            2'd2:    load_data = {{32{signed_q & rd_shift[31]}}, rd_shift[31:0]};
            default: load_data = rd_shift;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            off_q          <= 3'd0;
            size_q         <= 2'd0;
            signed_q       <= 1'b0;
            wen_q          <= 1'b0;
            bus.daddr      <= '0;
            bus.dmask      <= '0;
            bus.dwdata     <= '0;
            bus.dwen       <= 1'b0;
            bus.resp_valid <= 1'b0;
            bus.resp_data  <= '0;
            bus.resp_err   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        if (misaligned) begin
                            // Memory port is left untouched; the error response
                            // is presented one cycle later from RESP.
                            bus.resp_err  <= 1'b1;
                            bus.resp_data <= '0;
                            state         <= RESP;
                        end else begin
                            bus.daddr  <= {bus.req_addr[XLEN-1:3], 3'b000};
                            bus.dmask  <= req_mask;
                            bus.dwdata <= bus.req_wdata << {req_off, 3'b000};
                            bus.dwen   <= bus.req_wen;
                            off_q      <= req_off;
                            size_q     <= bus.req_size;
                            signed_q   <= bus.req_signed;
                            wen_q      <= bus.req_wen;
                            state      <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    // The memory samples the port at this edge; daddr/dwdata keep
                    // their values, dwen=0 keeps later cycles from writing.
                    bus.dwen  <= 1'b0;
                    bus.dmask <= '0;
                    state     <= WAIT;
                end
                WAIT: begin
                    bus.resp_data  <= wen_q ? '0 : load_data;
                    bus.resp_err   <= 1'b0;
                    bus.resp_valid <= 1'b1;
                    state          <= RESP;
                end
                RESP: begin
                    if (!bus.resp_valid) begin
                        bus.resp_valid <= 1'b1;
                    end else if (bus.resp_ready) begin
                        bus.resp_valid <= 1'b0;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
